// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port unified memory
// Optional MEM_ARB_FAIR_EN: caps consecutive data grants while a fetch is waiting.
module mem_arbiter #(
    parameter int BIN_DIG    = 32,
    parameter int ADDR_W     = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [BIN_DIG-1:0] if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BIN_DIG-1:0] d_wdata,
    input  logic [3:0]         d_be,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [BIN_DIG-1:0] d_rdata,
    input  logic               flush,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BIN_DIG-1:0] mem_wdata,
    output logic [3:0]         mem_be,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [BIN_DIG-1:0] mem_rdata,
    output logic               stall_if,
    output logic               stall_d
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t               state, state_nxt;
    logic                 owner, drop;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [BIN_DIG-1:0]   lat_wdata;
    logic [3:0]           lat_be;
    logic                 idle_live, fair_pick, grant_d, grant_i;

    if (FAIR_LIMIT < 1 || FAIR_LIMIT > 7) begin : g_fair_limit_check
        $error("mem_arbiter: FAIR_LIMIT must be in 1..7");
    end

    // Grants are gated by reset so nothing pulses while the core is held.
    assign idle_live = (state == S_IDLE) && RST;

`ifdef MEM_ARB_FAIR_EN
    logic [2:0] fair_cnt;
    assign fair_pick = (fair_cnt == 3'(FAIR_LIMIT)) && if_req && !flush;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fair_cnt <= '0;
        end else if (grant_i) begin
            fair_cnt <= '0;
        end else if (grant_d && if_req && fair_cnt != 3'd7) begin
            fair_cnt <= fair_cnt + 3'd1;
        end
    end
`else
    assign fair_pick = 1'b0;
`endif

    assign grant_d = idle_live && d_req && !fair_pick;
    assign grant_i = idle_live && if_req && !flush && !grant_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_d || grant_i) state_nxt = S_ISSUE;
            S_ISSUE: if (mem_gnt)            state_nxt = S_WAIT;
            S_WAIT:  if (mem_rvalid)         state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner     <= OWN_I;
            drop      <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (grant_d) begin
            owner     <= OWN_D;
            lat_we    <= d_we;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_be    <= d_be;
        end else if (grant_i) begin
            owner     <= OWN_I;
            drop      <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_be    <= 4'b1111;
        end else if (flush && owner == OWN_I && state != S_IDLE) begin
            // The memory cycle still runs to completion; only the response is dropped.
            drop <= 1'b1;
        end
    end

    always_comb begin
        if_gnt    = grant_i;
        d_gnt     = grant_d;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        case (state)
            S_ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_be    = lat_be;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (owner == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = lat_we ? '0 : mem_rdata;
                    end else if (!drop && !flush) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
        stall_if = RST && ((if_req && !grant_i) ||
                           (owner == OWN_I && state != S_IDLE && !if_rvalid));
        stall_d  = RST && ((d_req && !grant_d) ||
                           (owner == OWN_D && state != S_IDLE && !d_rvalid));
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_if, stall_d;

    integer tests = 0;
    integer fails = 0;

    typedef struct packed {
        logic        side;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic        gnt_en = 1'b1;
    logic        rv_hold = 1'b0;
    logic        pending = 1'b0;
    logic [31:0] addr_q = '0;
    logic [139:0] all_out;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .CLK(clk), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_d(stall_d)
    );

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = pending && !rv_hold;
    assign mem_rdata  = mem_rvalid ? model_data(addr_q) : 32'h0;
    assign all_out = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we,
                      mem_addr, mem_wdata, mem_be, stall_if, stall_d};

    // Memory model: accepts in the issue cycle, completes at the earliest one cycle later.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            pending <= 1'b1;
            addr_q  <= mem_addr;
        end else if (mem_rvalid) begin
            pending <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (if_rvalid || d_rvalid) begin
            tests = tests + 1;
            if (if_rvalid && d_rvalid) begin
                fails = fails + 1;
                $display("FAIL resp_both: if_rvalid=1 d_rvalid=1, required only one");
            end else if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL resp_unexpected: side=%0d data=%h, required no response",
                         d_rvalid, d_rvalid ? d_rdata : if_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.side !== d_rvalid || e.data !== (d_rvalid ? d_rdata : if_rdata)) begin
                    fails = fails + 1;
                    $display("FAIL resp_data: side=%0d data=%h, required side=%0d data=%h",
                             d_rvalid, d_rvalid ? d_rdata : if_rdata, e.side, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests = tests + 1;
        if (all_out !== '0) begin
            fails = fails + 1;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        step();
        RST = 1'b1;
        @(negedge clk);
        tests = tests + 1;
        if (all_out !== '0) begin
            fails = fails + 1;
            $display("FAIL idle_outputs: got %h, required 0", all_out);
        end
        step();
    endtask

    task automatic test_fetch_only();
        if_req = 1'b1;
        if_addr = 32'h100;
        exp_q.push_back({1'b0, 32'h0000_0013});
        @(negedge clk);
        tests = tests + 1;
        if (if_gnt !== 1'b1 || mem_req !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL fetch_gnt: if_gnt=%b mem_req=%b, required 1 0", if_gnt, mem_req);
        end
        step();
        if_req = 1'b0;
        @(negedge clk);
        tests = tests + 1;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100} || stall_if !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL fetch_issue: req=%b we=%b addr=%h stall_if=%b, required 1 0 100 1",
                     mem_req, mem_we, mem_addr, stall_if);
        end
        step();
        @(negedge clk);
        tests = tests + 1;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin
            fails = fails + 1;
            $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h, required 1 00000013",
                     if_rvalid, if_rdata);
        end
        step();
        @(negedge clk);
        tests = tests + 1;
        if (stall_if !== 1'b0 || mem_req !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL fetch_done: stall_if=%b mem_req=%b, required 0 0", stall_if, mem_req);
        end
        step();
    endtask

    task automatic test_conflict();
        if_req = 1'b1;
        if_addr = 32'h104;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h2000;
        d_be = 4'b1111;
        exp_q.push_back({1'b1, model_data(32'h2000)});
        @(negedge clk);
        tests = tests + 1;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || stall_if !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL conflict_first: d_gnt=%b if_gnt=%b stall_if=%b, required 1 0 1",
                     d_gnt, if_gnt, stall_if);
        end
        step();
        d_req = 1'b0;
        step();
        step();
        exp_q.push_back({1'b0, model_data(32'h104)});
        @(negedge clk);
        tests = tests + 1;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL conflict_second: if_gnt=%b d_gnt=%b, required 1 0", if_gnt, d_gnt);
        end
        step();
        if_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_store();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h3000;
        d_wdata = 32'hDEAD_BEEF;
        d_be = 4'b0011;
        exp_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        tests = tests + 1;
        if (d_gnt !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL store_gnt: d_gnt=%b, required 1", d_gnt);
        end
        step();
        d_req = 1'b0;
        d_we = 1'b0;
        @(negedge clk);
        tests = tests + 1;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_d} !==
            {1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011, 1'b1}) begin
            fails = fails + 1;
            $display("FAIL store_issue: req=%b we=%b addr=%h wdata=%h be=%b stall_d=%b, required 1 1 3000 deadbeef 0011 1",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_d);
        end
        step();
        @(negedge clk);
        tests = tests + 1;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
            fails = fails + 1;
            $display("FAIL store_resp: d_rvalid=%b d_rdata=%h, required 1 0", d_rvalid, d_rdata);
        end
        step();
        step();
    endtask

    task automatic test_flush();
        rv_hold = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h200;
        @(negedge clk);
        tests = tests + 1;
        if (if_gnt !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL flush_gnt: if_gnt=%b, required 1", if_gnt);
        end
        step();
        if_req = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        rv_hold = 1'b0;
        @(negedge clk);
        tests = tests + 1;
        if (mem_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL flush_drop: mem_rvalid=%b if_rvalid=%b, required 1 0",
                     mem_rvalid, if_rvalid);
        end
        step();
        if_req = 1'b1;
        if_addr = 32'h300;
        exp_q.push_back({1'b0, model_data(32'h300)});
        @(negedge clk);
        tests = tests + 1;
        if (if_gnt !== 1'b1 || stall_if !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL flush_refetch: if_gnt=%b stall_if=%b, required 1 0", if_gnt, stall_if);
        end
        step();
        if_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_midop();
        rv_hold = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h2400;
        d_be = 4'b1111;
        step();
        d_req = 1'b0;
        step();
        step();
        RST = 1'b0;
        #1;
        tests = tests + 1;
        if (all_out !== '0) begin
            fails = fails + 1;
            $display("FAIL reset_midop: got %h, required 0", all_out);
        end
        step();
        RST = 1'b1;
        rv_hold = 1'b0;
        @(negedge clk);
        tests = tests + 1;
        if (mem_rvalid !== 1'b1 || all_out !== '0) begin
            fails = fails + 1;
            $display("FAIL late_rvalid: mem_rvalid=%b outputs=%h, required 1 0", mem_rvalid, all_out);
        end
        step();
        step();
    endtask

    task automatic test_fairness();
        int ngrant, first_i, n_i, last_cyc, gap_bad;
        ngrant = 0;
        first_i = 0;
        n_i = 0;
        last_cyc = -1;
        gap_bad = 0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h4000;
        d_be = 4'b1111;
        if_req = 1'b1;
        if_addr = 32'h500;
        for (int cyc = 0; cyc < 100 && ngrant < 20; cyc++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                ngrant++;
                if (last_cyc >= 0 && cyc - last_cyc != 3) gap_bad++;
                last_cyc = cyc;
                if (if_gnt) begin
                    n_i++;
                    if (first_i == 0) first_i = ngrant;
                    exp_q.push_back({1'b0, model_data(32'h500)});
                end else begin
                    exp_q.push_back({1'b1, model_data(32'h4000)});
                end
            end
            step();
        end
        d_req = 1'b0;
        if_req = 1'b0;
        repeat (5) step();
        tests = tests + 1;
        if (ngrant != 20 || gap_bad != 0) begin
            fails = fails + 1;
            $display("FAIL fair_throughput: grants=%0d bad_gaps=%0d, required 20 0", ngrant, gap_bad);
        end
        tests = tests + 1;
`ifdef MEM_ARB_FAIR_EN
        if (first_i != 5 || n_i != 4) begin
            fails = fails + 1;
            $display("FAIL fair_order: first_if_grant=%0d if_grants=%0d, required 5 4", first_i, n_i);
        end
`else
        if (n_i != 0) begin
            fails = fails + 1;
            $display("FAIL strict_priority: if_grants=%0d, required 0", n_i);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_conflict();
        test_store();
        test_flush();
        test_reset_midop();
        test_fairness();
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: %0d responses missing, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
